// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte out on device-generated clocks and reports the ack.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic [PW-1:0]   phase_q, phase_d;
  logic [TW-1:0]   wd_q, wd_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      idx_q, idx_d;
  logic            parity_q, parity_d;
  logic            ack_q, ack_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            tmo_q, tmo_d;

  logic clk_fall, clk_s, data_s, on_line;

  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign on_line  = state_q inside {S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE};

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      phase_q     <= '0;
      wd_q        <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      parity_q    <= 1'b0;
      ack_q       <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      phase_q     <= phase_d;
      wd_q        <= wd_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      ack_q       <= ack_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wd_d      = '0;
    shift_d   = shift_q;
    idx_d     = idx_q;
    parity_d  = parity_q;
    ack_d     = ack_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    tmo_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = ~^tx_data;
          phase_d  = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (phase_q == INH_LAST) begin
          phase_d   = '0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_RTS: begin
        if (phase_q == RTS_LAST) begin
          phase_d = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          idx_d     = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (clk_fall) begin
          data_oe_d = ~parity_q;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          ack_d   = data_s;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d    = 1'b1;
          ack_err_d = ack_q;
          state_d   = S_IDLE;
        end
      end
    endcase

    // Watchdog: a completed frame in the same cycle wins over the abort.
    if (on_line && state_d != S_IDLE) begin
      if (clk_fall) begin
        wd_d = '0;
      end else if (wd_q == TMO_LAST) begin
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
        tmo_d     = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a simple device model, table
// frames, random frames, and hand sequences for timeout and mid-frame clear.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int RTS = 2;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       clr;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_err, timeout_err;
  logic       dev_clk, dev_data;
  logic       ps2_clk_l, ps2_data_l;

  assign ps2_clk_l  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_l = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk_l), .ps2_data(ps2_data_l),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  // Pulse bookkeeping, sampled just before each rising edge.
  int   done_cnt = 0, ackerr_cnt = 0, tmo_cnt = 0, viol_cnt = 0;
  logic pd = 1'b0, pa = 1'b0, pt = 1'b0;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    done_cnt   <= done_cnt + (done ? 1 : 0);
    ackerr_cnt <= ackerr_cnt + (ack_err ? 1 : 0);
    tmo_cnt    <= tmo_cnt + (timeout_err ? 1 : 0);
    if ((done && pd) || (ack_err && pa) || (timeout_err && pt) ||
        (done && timeout_err) || (ack_err && !done))
      viol_cnt <= viol_cnt + 1;
    pd <= done;
    pa <= ack_err;
    pt <= timeout_err;
  end

  typedef struct {
    logic [7:0] b;
    logic       ack;
    logic       parity;
    bit         inject;
    int         hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Line image of a host frame: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] r;
    int ones;
    ones = 0;
    r    = '0;
    for (int i = 0; i < 8; i++) begin
      r[i+1] = ((b >> i) & 8'd1) != 0;
      ones  += ((b >> i) & 8'd1) != 0 ? 1 : 0;
    end
    r[9]  = (ones % 2 == 0);
    r[10] = 1'b1;
    return r;
  endfunction

  task automatic start_frame(input logic [7:0] b, output int inh, output int rts, output bit ok);
    inh = 0; rts = 0; ok = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("busy after accept", busy, 1);
    for (int g = 0; g < 100; g++) begin
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) rts++;
      else if (!ps2_clk_oe && ps2_data_oe) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic dev_edges(input int n, input logic ack, input bit inject, output logic [10:0] rx);
    rx    = '0;
    rx[0] = ps2_data_l;
    for (int e = 1; e <= n; e++) begin
      if (e == 11) dev_data = ack;
      tick(4);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      if (inject && e == 3) begin tx_data = 8'h55; tx_valid = 1'b1; end
      tick();
      if (inject && e == 3) tx_valid = 1'b0;
      tick(4);
      if (e <= 10) rx[e] = ps2_data_l;
      dev_clk = 1'b1;
    end
  endtask

  task automatic do_frame(input vec_t v, input bit check_par, input string tag);
    int inh, rts, d0, a0, t0;
    bit ok;
    logic [10:0] rx;
    d0 = done_cnt; a0 = ackerr_cnt; t0 = tmo_cnt;
    check({tag, " ready"}, tx_ready, 1);
    start_frame(v.b, inh, rts, ok);
    check({tag, " reached data"}, ok, 1);
    check({tag, " inhibit cycles"}, inh, INH);
    check({tag, " rts cycles"}, rts, RTS);
    dev_edges(11, v.ack, v.inject, rx);
    check({tag, " frame bits"}, rx, model_frame(v.b));
    if (check_par) check({tag, " parity bit"}, rx[9], v.parity);
    if (v.hold > 0 && v.ack == 1'b0) begin
      tick(v.hold);
      check({tag, " done withheld"}, done_cnt - d0, 0);
    end
    dev_data = 1'b1;
    for (int g = 0; g < 40 && (done_cnt - d0) == 0; g++) tick();
    tick(2);
    check({tag, " done count"}, done_cnt - d0, 1);
    check({tag, " ack_err count"}, ackerr_cnt - a0, v.ack ? 1 : 0);
    check({tag, " no timeout"}, tmo_cnt - t0, 0);
    check({tag, " idle ready"}, {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
  endtask

  vec_t tbl[8];

  initial begin
    int inh, rts, d0, t0, lat;
    bit ok, seen;
    logic [10:0] rx;
    vec_t rv;

    tbl[0] = '{8'hED, 1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{8'hF4, 1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{8'hED, 1'b0, 1'b1, 1'b1, 0};
    tbl[3] = '{8'hED, 1'b0, 1'b1, 1'b0, 30};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 0};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 5};
    tbl[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 0};
    tbl[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 0};

    clr = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    tick(3);
    check("reset outputs",
          {ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_err, timeout_err}, 7'b0010000);
    clr = 1'b0;
    tick(4);

    foreach (tbl[i]) do_frame(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int k = 0; k < 6; k++) begin
      rv.b      = 8'($urandom);
      rv.ack    = 1'($urandom_range(0, 1));
      rv.parity = 1'b0;
      rv.inject = 1'($urandom_range(0, 1));
      rv.hold   = $urandom_range(0, 20);
      do_frame(rv, 1'b0, $sformatf("rand%0d", k));
    end

    // Device stops clocking after four data bits.
    d0 = done_cnt; t0 = tmo_cnt;
    start_frame(8'hED, inh, rts, ok);
    check("tmo reached data", ok, 1);
    dev_edges(4, 1'b0, 1'b0, rx);
    seen = 0;
    for (int g = 0; g < 400; g++) begin
      if (timeout_err) begin seen = 1; break; end
      tick();
    end
    lat = cyc - last_fall_cyc;
    check("tmo pulse seen", seen, 1);
    check("tmo latency window", (lat >= TMO && lat <= TMO + 8), 1);
    check("tmo lines released", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    tick(3);
    check("tmo count", tmo_cnt - t0, 1);
    check("tmo no done", done_cnt - d0, 0);

    // Clear asserted while in request-to-send.
    d0 = done_cnt; t0 = tmo_cnt;
    tx_data = 8'hED; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    seen = 0;
    for (int g = 0; g < 50; g++) begin
      if (ps2_clk_oe && ps2_data_oe) begin seen = 1; break; end
      tick();
    end
    check("clr reached rts", seen, 1);
    clr = 1'b1;
    tick();
    check("clr lines released", {ps2_clk_oe, ps2_data_oe, tx_ready, busy}, 4'b0010);
    clr = 1'b0;
    tick(5);
    check("clr no done", done_cnt - d0, 0);
    check("clr no timeout", tmo_cnt - t0, 0);
    do_frame(tbl[0], 1'b1, "post_clr");

    tick(3);
    check("pulse rules", viol_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
